demux_1x4_buf: RTL and testbench

//  Buffered 1-to-4 demultiplexer with valid/ready handshakes; the distributing counterpart of Mux4x1.

---
 rtl/demux_1x4_buf_pkg.sv | 25 ++
 rtl/demux_1x4_buf_lane_fifo2.sv | 80 ++++++++
 rtl/demux_1x4_buf.sv | 56 +++++
 tb/tb_demux_1x4_buf.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/demux_1x4_buf_pkg.sv
// Shared constants and helpers for the buffered 1-to-4 demultiplexer.
package demux_1x4_buf_pkg;

   localparam int unsigned NUM_LANES  = 4;
   localparam int unsigned SEL_W      = 2;
   localparam int unsigned LANE_DEPTH = 2;

   typedef logic [SEL_W-1:0] sel_t;

   // Occupancy of a 2-entry lane FIFO
   typedef enum logic [1:0] {
      CNT_EMPTY = 2'd0,
      CNT_ONE   = 2'd1,
      CNT_FULL  = 2'd2
   } lane_cnt_e;

   // One-hot decode of a lane select
   function automatic logic [NUM_LANES-1:0] sel_decode(input sel_t s);
      logic [NUM_LANES-1:0] d;
      d    = '0;
      d[s] = 1'b1;
      return d;
   endfunction

endpackage

// File: rtl/demux_1x4_buf_lane_fifo2.sv
// Two-entry lane FIFO: one write port, one read port, zero output when empty.
module lane_fifo2
   import demux_1x4_buf_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic         WrEn,
   input  logic [W-1:0] WrData,
   input  logic         RdEn,
   output logic [W-1:0] RdData,
   output logic         Valid,
   output logic         Full
);

   lane_cnt_e    cnt_q, cnt_d;
   logic         rd_q, rd_d;
   logic         wr_q, wr_d;
   logic [W-1:0] mem_q [LANE_DEPTH];
   logic [W-1:0] mem_d [LANE_DEPTH];
   logic         drain;
   logic         write;

   // Next-state: pointer advance, entry write and occupancy update
   always_comb begin
      cnt_d = cnt_q;
      rd_d  = rd_q;
      wr_d  = wr_q;
      mem_d = mem_q;
      drain = RdEn & (cnt_q != CNT_EMPTY);
      // a full lane still takes a word when its head leaves the same cycle
      write = WrEn & ((cnt_q != CNT_FULL) | drain);
      if (write) begin
         mem_d[wr_q] = WrData;
         wr_d        = ~wr_q;
      end
      if (drain) begin
         rd_d = ~rd_q;
      end
      case ({write, drain})
         2'b10: begin
            case (cnt_q)
               CNT_EMPTY: cnt_d = CNT_ONE;
               default:   cnt_d = CNT_FULL;
            endcase
         end
         2'b01: begin
            case (cnt_q)
               CNT_FULL: cnt_d = CNT_ONE;
               default:  cnt_d = CNT_EMPTY;
            endcase
         end
         default: cnt_d = cnt_q;
      endcase
   end

   // Control state register with synchronous reset
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_q <= CNT_EMPTY;
         rd_q  <= 1'b0;
         wr_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
      end
   end

   // Data storage; contents are masked by the count so no reset is needed
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign Valid  = (cnt_q != CNT_EMPTY);
   assign Full   = (cnt_q == CNT_FULL);
   assign RdData = Valid ? mem_q[rd_q] : '0;

endmodule

// File: rtl/demux_1x4_buf.sv
// Buffered 1-to-4 demultiplexer with per-lane 2-entry FIFOs and valid/ready handshakes.
module demux_1x4_buf
   import demux_1x4_buf_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [W-1:0]         In,
   input  logic [SEL_W-1:0]     Select,
   input  logic                 InValid,
   output logic                 InReady,
   output logic [W-1:0]         Out0,
   output logic [W-1:0]         Out1,
   output logic [W-1:0]         Out2,
   output logic [W-1:0]         Out3,
   output logic [NUM_LANES-1:0] OutValid,
   input  logic [NUM_LANES-1:0] OutReady,
   output logic                 Empty
);

   logic [NUM_LANES-1:0] lane_valid;
   logic [NUM_LANES-1:0] lane_full;
   logic [NUM_LANES-1:0] wr_en;
   logic [W-1:0]         lane_data [NUM_LANES];

   // Ready mux on the selected lane and one-hot write enable decode
   always_comb begin
      InReady = 1'b0;
      if (!RESET) begin
         InReady = ~lane_full[Select] | (lane_valid[Select] & OutReady[Select]);
      end
      wr_en = sel_decode(Select) & {NUM_LANES{InValid & InReady}};
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_fifo2 #(.W(W)) u_lane (
         .CLK    (CLK),
         .RESET  (RESET),
         .WrEn   (wr_en[g]),
         .WrData (In),
         .RdEn   (OutReady[g]),
         .RdData (lane_data[g]),
         .Valid  (lane_valid[g]),
         .Full   (lane_full[g])
      );
   end

   assign Out0     = lane_data[0];
   assign Out1     = lane_data[1];
   assign Out2     = lane_data[2];
   assign Out3     = lane_data[3];
   assign OutValid = lane_valid;
   assign Empty    = ~|lane_valid;

endmodule

// File: tb/tb_demux_1x4_buf.sv
// Self-checking bench for demux_1x4_buf: vector table, directed corner sequences, random traffic.
module tb_demux_1x4_buf;

   logic       CLK;
   logic       RESET;
   logic [7:0] In;
   logic [1:0] Select;
   logic       InValid;
   logic       InReady;
   logic [7:0] Out0, Out1, Out2, Out3;
   logic [3:0] OutValid;
   logic [3:0] OutReady;
   logic       Empty;
   logic [7:0] outs [4];

   int unsigned checks   = 0;
   int unsigned failures = 0;
   bit          model_ok = 0;
   bit          last_acc = 0;
   logic [7:0]  sbq [4][$];

   demux_1x4_buf #(.W(8)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .In       (In),
      .Select   (Select),
      .InValid  (InValid),
      .InReady  (InReady),
      .Out0     (Out0),
      .Out1     (Out1),
      .Out2     (Out2),
      .Out3     (Out3),
      .OutValid (OutValid),
      .OutReady (OutReady),
      .Empty    (Empty)
   );

   assign outs[0] = Out0;
   assign outs[1] = Out1;
   assign outs[2] = Out2;
   assign outs[3] = Out3;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic       rst;
      logic       inv;
      logic [7:0] din;
      logic [1:0] sel;
      logic [3:0] ordy;
      logic       chk_v;
      logic       exp_rdy;
      logic [3:0] exp_v;
   } vec_t;

   vec_t tab [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic inv, input logic [7:0] din,
                        input logic [1:0] sel, input logic [3:0] ordy);
      RESET    = rst;
      InValid  = inv;
      In       = din;
      Select   = sel;
      OutReady = ordy;
   endtask

   function automatic logic model_ready();
      int unsigned s;
      s = int'(Select);
      return !RESET && ((sbq[s].size() < 2) || (sbq[s].size() != 0 && OutReady[s]));
   endfunction

   // One clock cycle: compare pre-edge outputs against the model, update scoreboard, advance.
   task automatic step(input bit ct, input logic er, input logic [3:0] ev);
      logic       mrdy;
      logic [3:0] mv;
      logic [7:0] mo;
      #1;
      if (ct) begin
         chk("tab_inready", InReady, er);
         chk("tab_outvalid", OutValid, ev);
      end
      mrdy = model_ready();
      if (!model_ok) begin
         if (RESET) chk("inready_in_reset", InReady, 1'b0);
      end else begin
         chk("inready", InReady, mrdy);
         for (int n = 0; n < 4; n++) begin
            mv[n] = (sbq[n].size() != 0);
            mo    = mv[n] ? sbq[n][0] : 8'h00;
            chk($sformatf("out%0d", n), outs[n], mo);
         end
         chk("outvalid", OutValid, mv);
         chk("empty", Empty, (mv == 4'b0000));
      end
      last_acc = 0;
      if (model_ok && !RESET) begin
         for (int n = 0; n < 4; n++)
            if (mv[n] && OutReady[n]) void'(sbq[n].pop_front());
         if (InValid && mrdy) begin
            sbq[int'(Select)].push_back(In);
            last_acc = 1;
         end
      end
      @(posedge CLK);
      #1;
      if (RESET) begin
         for (int n = 0; n < 4; n++) sbq[n].delete();
         model_ok = 1;
      end
   endtask

   function automatic vec_t mk(logic rst, logic inv, logic [7:0] din, logic [1:0] sel,
                               logic [3:0] ordy, logic chk_v, logic exp_rdy, logic [3:0] exp_v);
      vec_t v;
      v.rst = rst; v.inv = inv; v.din = din; v.sel = sel; v.ordy = ordy;
      v.chk_v = chk_v; v.exp_rdy = exp_rdy; v.exp_v = exp_v;
      return v;
   endfunction

   initial begin
      // reset held two cycles with InValid asserted
      tab[0]  = mk(1, 1, 8'hFF, 2'd0, 4'b0000, 0, 0, 4'b0000);
      tab[1]  = mk(1, 1, 8'hFE, 2'd1, 4'b0000, 1, 0, 4'b0000);
      // routing with all sinks ready
      tab[2]  = mk(0, 1, 8'hA0, 2'd0, 4'b1111, 1, 1, 4'b0000);
      tab[3]  = mk(0, 1, 8'hA1, 2'd1, 4'b1111, 1, 1, 4'b0001);
      tab[4]  = mk(0, 1, 8'hA2, 2'd2, 4'b1111, 1, 1, 4'b0010);
      tab[5]  = mk(0, 1, 8'hA3, 2'd3, 4'b1111, 1, 1, 4'b0100);
      tab[6]  = mk(0, 0, 8'h00, 2'd3, 4'b1111, 1, 1, 4'b1000);
      // backpressure on lane 2
      tab[7]  = mk(0, 1, 8'h11, 2'd2, 4'b0000, 1, 1, 4'b0000);
      tab[8]  = mk(0, 1, 8'h22, 2'd2, 4'b0000, 1, 1, 4'b0100);
      tab[9]  = mk(0, 1, 8'h33, 2'd2, 4'b0000, 1, 0, 4'b0100);
      tab[10] = mk(0, 1, 8'h33, 2'd2, 4'b0100, 1, 1, 4'b0100);
      tab[11] = mk(0, 0, 8'h00, 2'd2, 4'b0100, 1, 1, 4'b0100);
      tab[12] = mk(0, 0, 8'h00, 2'd2, 4'b0100, 1, 1, 4'b0100);
      // lane isolation: lane 1 full, lane 3 still accepts
      tab[13] = mk(0, 1, 8'h01, 2'd1, 4'b0000, 1, 1, 4'b0000);
      tab[14] = mk(0, 1, 8'h02, 2'd1, 4'b0000, 1, 1, 4'b0010);
      tab[15] = mk(0, 1, 8'h55, 2'd3, 4'b0000, 1, 1, 4'b0010);
      tab[16] = mk(0, 0, 8'h00, 2'd1, 4'b0000, 1, 0, 4'b1010);

      for (int i = 0; i < 17; i++) begin
         drive(tab[i].rst, tab[i].inv, tab[i].din, tab[i].sel, tab[i].ordy);
         step(tab[i].chk_v, tab[i].exp_rdy, tab[i].exp_v);
      end

      // drain lanes 1 and 3
      drive(0, 0, 8'h00, 2'd1, 4'b1010);
      step(1, 1, 4'b1010);
      step(1, 1, 4'b0010);
      step(1, 1, 4'b0000);

      // full lane 0 with simultaneous accept and drain across pointer wrap
      drive(0, 1, 8'hC0, 2'd0, 4'b0000); step(1, 1, 4'b0000);
      drive(0, 1, 8'hC1, 2'd0, 4'b0000); step(1, 1, 4'b0001);
      for (int i = 0; i < 6; i++) begin
         drive(0, 1, 8'hD0 + 8'(i), 2'd0, 4'b0001);
         step(1, 1, 4'b0001);
      end
      drive(0, 0, 8'h00, 2'd0, 4'b0000); step(1, 0, 4'b0001);
      drive(0, 0, 8'h00, 2'd0, 4'b0001); step(1, 1, 4'b0001);
      step(1, 1, 4'b0001);
      step(1, 1, 4'b0000);

      // mid-operation reset with lanes 0 and 2 full
      drive(0, 1, 8'hE0, 2'd0, 4'b0000); step(0, 0, 4'b0000);
      drive(0, 1, 8'hE1, 2'd0, 4'b0000); step(0, 0, 4'b0000);
      drive(0, 1, 8'hE2, 2'd2, 4'b0000); step(0, 0, 4'b0000);
      drive(0, 1, 8'hE3, 2'd2, 4'b0000); step(1, 1, 4'b0101);
      drive(1, 1, 8'hFF, 2'd2, 4'b1111); step(1, 0, 4'b0101);
      drive(0, 1, 8'h7E, 2'd2, 4'b0000); step(1, 1, 4'b0000);
      drive(0, 0, 8'h00, 2'd2, 4'b0100); step(1, 1, 4'b0100);
      step(1, 1, 4'b0000);

      // random traffic; a refused word is held until accepted
      for (int i = 0; i < 400; i++) begin
         if (!(InValid && !last_acc)) begin
            InValid = ($urandom_range(0, 3) != 0);
            In      = 8'($urandom);
            Select  = 2'($urandom);
         end
         OutReady = 4'($urandom);
         RESET    = 1'b0;
         step(0, 0, 4'b0000);
      end

      drive(0, 0, 8'h00, 2'd0, 4'b1111);
      for (int i = 0; i < 3; i++) step(0, 0, 4'b0000);
      step(1, 1, 4'b0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
